// File: rtl/sprite_blitter_pkg.sv
// blit_pkg: shared constants and types for the sprite blitter and the
// animation controller that drives it.
//   - Sprite and frame geometry (SPR_W, SPR_H, SCR_W, SCR_H).
//   - Blitter FSM state encoding.
//   - 9-bit RGB 3:3:3 colour type and the named colours used by main.
//   - slot_index(): maps (row, col) to a bit position in a sprite mask.
package blit_pkg;

  localparam int SPR_W = 4;               // power of two
  localparam int SPR_H = 4;               // power of two
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int SPR_N = SPR_W * SPR_H;
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  typedef logic [8:0]       colour_t;
  typedef logic [1:0]       sprite_id_t;
  typedef logic [SPR_N-1:0] sprite_mask_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } blit_state_e;

  localparam colour_t BG_COLOUR  = 9'h000;
  localparam colour_t COL_BLACK  = 9'h000;
  localparam colour_t COL_RED    = 9'h1C0;
  localparam colour_t COL_GREEN  = 9'h038;
  localparam colour_t COL_BLUE   = 9'h007;
  localparam colour_t COL_YELLOW = 9'h1F8;
  localparam colour_t COL_WHITE  = 9'h1FF;

  // Both dimensions are powers of two, so row*SPR_W+col is a concatenation.
  function automatic logic [ROW_W+COL_W-1:0] slot_index(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: request handshake from the animation controller plus
// the pixel-write stream towards vga_adapter.
//   master: requester side (drives req_*, observes ready/pixels/done).
//   slave : blitter side (consumes req_*, drives ready/pixels/done).
interface sprite_blitter_if;
  import blit_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  sprite_id_t req_sprite;
  colour_t    req_colour;
  logic       req_erase;

  logic [7:0] oX;
  logic [6:0] oY;
  colour_t    oColour;
  logic       oPlot;
  logic       done;

  modport master (
    output req_valid, req_x, req_y, req_sprite, req_colour, req_erase,
    input  req_ready, oX, oY, oColour, oPlot, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_sprite, req_colour, req_erase,
    output req_ready, oX, oY, oColour, oPlot, done
  );

endinterface

// File: rtl/sprite_blitter_rom.sv
// sprite_rom: combinational sprite mask table.
//   id   in  2-bit sprite id
//   mask out SPR_W*SPR_H-bit mask, bit 0 = top-left, row-major
module sprite_rom
  import blit_pkg::*;
(
  input  sprite_id_t   id,
  output sprite_mask_t mask
);

  always_comb begin
    mask = '0;
    case (id)
      2'd0:    mask = 16'hFFFF;   // solid block (car)
      2'd1:    mask = 16'h6FF6;   // coin
      2'd2:    mask = 16'h9669;
      default: mask = 16'h0000;   // blank
    endcase
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: expands one "draw sprite S at (x,y) in colour C" request
// into SPR_W*SPR_H single-pixel write slots, clipped to the frame.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : req_valid/req_ready handshake with req_x/y/sprite/colour/
//                  erase; oX/oY/oColour/oPlot pixel stream; done pulse.
// Every slot takes one cycle whether or not it plots, so draw time is fixed.
module sprite_blitter
  import blit_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  sprite_blitter_if.slave bus
);

  blit_state_e      state_q, state_d;
  logic [7:0]       bx_q, bx_d;
  logic [6:0]       by_q, by_d;
  sprite_id_t       spr_q, spr_d;
  colour_t          colour_q, colour_d;
  logic             erase_q, erase_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic [7:0]       ox_q, ox_d;
  logic [6:0]       oy_q, oy_d;
  colour_t          ocol_q, ocol_d;
  logic             oplot_q, oplot_d;
  logic             done_q, done_d;

  sprite_mask_t     mask;
  logic [8:0]       x_sum;
  logic [7:0]       y_sum;
  logic             slot_on;

  sprite_rom u_rom (
    .id   (spr_q),
    .mask (mask)
  );

  // One bit wider than the ports so that wrap-around is caught by the clip
  // test instead of landing back inside the frame.
  assign x_sum   = {1'b0, bx_q} + 9'(col_q);
  assign y_sum   = {1'b0, by_q} + 8'(row_q);
  assign slot_on = mask[slot_index(row_q, col_q)]
                 & (x_sum < 9'(SCR_W))
                 & (y_sum < 8'(SCR_H));

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    spr_d    = spr_q;
    colour_d = colour_q;
    erase_d  = erase_q;
    col_d    = col_q;
    row_d    = row_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    ocol_d   = ocol_q;
    oplot_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          bx_d     = bus.req_x;
          by_d     = bus.req_y;
          spr_d    = bus.req_sprite;
          colour_d = bus.req_colour;
          erase_d  = bus.req_erase;
          col_d    = '0;
          row_d    = '0;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        ox_d    = x_sum[7:0];
        oy_d    = y_sum[6:0];
        ocol_d  = erase_q ? BG_COLOUR : colour_q;
        oplot_d = slot_on;
        if (col_q == COL_W'(SPR_W - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(SPR_H - 1)) begin
            state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: begin
        // done is registered, so it appears together with the return to IDLE.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      spr_q    <= '0;
      colour_q <= '0;
      erase_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      ocol_q   <= '0;
      oplot_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      spr_q    <= spr_d;
      colour_q <= colour_d;
      erase_q  <= erase_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      ocol_q   <= ocol_d;
      oplot_q  <= oplot_d;
      done_q   <= done_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.oX        = ox_q;
  assign bus.oY        = oy_q;
  assign bus.oColour   = ocol_q;
  assign bus.oPlot     = oplot_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed testbench for sprite_blitter: hand-specified plot patterns per
// draw, slot-by-slot checks of coordinates, colour, plot, ready and done.
module tb_sprite_blitter;
  import blit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  sprite_blitter_if bus();

  sprite_blitter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns right after the accepting posedge with
  // req_valid still high so the caller decides what to drive next.
  task automatic start(input logic [7:0] x, input logic [6:0] y, input sprite_id_t s,
                       input colour_t c, input logic e, output int waited);
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_sprite = s;
    bus.req_colour = c;
    bus.req_erase  = e;
    bus.req_valid  = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 64) chk_eq("ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    $display("req x=%0d y=%0d spr=%0d col=%03h erase=%0b accepted at %0t after %0d wait cycles",
             x, y, s, c, e, $time, waited);
  endtask

  // Checks the 16 slots after an accept and the done cycle; ends at the
  // negedge of accept+17.
  task automatic check_draw(input string tag, input logic [7:0] bx, input logic [6:0] by,
                            input colour_t ecol, input logic [15:0] eplot);
    int n_plot = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] ex;
      logic [6:0] ey;
      ex = 8'(bx + (k % 4));
      ey = 7'(by + (k / 4));
      @(posedge clock);
      @(negedge clock);
      chk_eq($sformatf("%s_plot%0d", tag, k),  32'(bus.oPlot),     32'(eplot[k]));
      chk_eq($sformatf("%s_x%0d", tag, k),     32'(bus.oX),        32'(ex));
      chk_eq($sformatf("%s_y%0d", tag, k),     32'(bus.oY),        32'(ey));
      chk_eq($sformatf("%s_col%0d", tag, k),   32'(bus.oColour),   32'(ecol));
      chk_eq($sformatf("%s_ready%0d", tag, k), 32'(bus.req_ready), 32'd0);
      chk_eq($sformatf("%s_done%0d", tag, k),  32'(bus.done),      32'd0);
      if (bus.oPlot === 1'b1) n_plot++;
    end
    @(posedge clock);
    @(negedge clock);
    chk_eq({tag, "_done"},      32'(bus.done),      32'd1);
    chk_eq({tag, "_done_plot"}, 32'(bus.oPlot),     32'd0);
    chk_eq({tag, "_ready_end"}, 32'(bus.req_ready), 32'd1);
    $display("draw %s at (%0d,%0d) finished at %0t with %0d pixels", tag, bx, by, $time, n_plot);
  endtask

  task automatic drop_and_scramble();
    #1;
    bus.req_valid  = 1'b0;
    bus.req_x      = 8'hAA;
    bus.req_y      = 7'h55;
    bus.req_sprite = 2'd3;
    bus.req_colour = 9'h0FF;
    bus.req_erase  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int n_done;
    int n_plot;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_sprite = '0;
    bus.req_colour = '0;
    bus.req_erase  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    chk_eq("rst_plot",  32'(bus.oPlot),     32'd0);
    chk_eq("rst_done",  32'(bus.done),      32'd0);
    chk_eq("rst_x",     32'(bus.oX),        32'd0);
    chk_eq("rst_y",     32'(bus.oY),        32'd0);
    chk_eq("rst_col",   32'(bus.oColour),   32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: solid car block in red, inputs scrambled after accept
    start(8'd10, 7'd20, 2'd0, 9'h1C0, 1'b0, waited);
    drop_and_scramble();
    check_draw("t1", 8'd10, 7'd20, 9'h1C0, 16'hFFFF);
    @(posedge clock);
    @(negedge clock);
    chk_eq("t1_done_once", 32'(bus.done),      32'd0);
    chk_eq("t1_ready_idle", 32'(bus.req_ready), 32'd1);

    // 2: erase coin at origin; colour input ignored in favour of background
    start(8'd0, 7'd0, 2'd1, 9'h1FF, 1'b1, waited);
    drop_and_scramble();
    check_draw("t2", 8'd0, 7'd0, 9'h000, 16'h6FF6);

    // 3: bottom-right corner, only the 2x2 on-screen slots plot
    start(8'd158, 7'd118, 2'd0, 9'h038, 1'b0, waited);
    drop_and_scramble();
    check_draw("t3", 8'd158, 7'd118, 9'h038, 16'h0033);

    // 4: next request held high during a draw, accepted exactly at accept+18
    start(8'd40, 7'd30, 2'd2, 9'h007, 1'b0, waited);
    #1;
    bus.req_x      = 8'd60;
    bus.req_y      = 7'd70;
    bus.req_sprite = 2'd0;
    bus.req_colour = 9'h1F8;
    bus.req_erase  = 1'b0;
    check_draw("t4a", 8'd40, 7'd30, 9'h007, 16'h9669);
    start(8'd60, 7'd70, 2'd0, 9'h1F8, 1'b0, waited);
    chk_eq("t4_accept_gap", 32'(waited), 32'd0);
    drop_and_scramble();
    check_draw("t4b", 8'd60, 7'd70, 9'h1F8, 16'hFFFF);

    // 5: reset at accept+5 abandons the draw
    start(8'd30, 7'd40, 2'd0, 9'h1C0, 1'b0, waited);
    drop_and_scramble();
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk_eq("t5_plot_before", 32'(bus.oPlot), 32'd1);
    chk_eq("t5_x_before",    32'(bus.oX),    32'd33);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_eq("t5_plot",  32'(bus.oPlot),     32'd0);
    chk_eq("t5_ready", 32'(bus.req_ready), 32'd1);
    chk_eq("t5_state", 32'(dut.state_q),   32'(IDLE));
    chk_eq("t5_x",     32'(bus.oX),        32'd0);
    chk_eq("t5_col",   32'(bus.oColour),   32'd0);
    reset  = 1'b0;
    n_done = 0;
    n_plot = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1)  n_done++;
      if (bus.oPlot === 1'b1) n_plot++;
    end
    chk_eq("t5_no_done", 32'(n_done), 32'd0);
    chk_eq("t5_no_plot", 32'(n_plot), 32'd0);
    $display("abort test finished at %0t", $time);

    // 6: blank sprite takes full time with no plots
    start(8'd50, 7'd50, 2'd3, 9'h038, 1'b0, waited);
    drop_and_scramble();
    check_draw("t6", 8'd50, 7'd50, 9'h038, 16'h0000);

    // 7: origin past the frame edge; coordinates wrap on the ports, nothing plots
    start(8'd255, 7'd127, 2'd0, 9'h1FF, 1'b0, waited);
    drop_and_scramble();
    check_draw("t7", 8'd255, 7'd127, 9'h1FF, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
